// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolling obstacle field for the Flappy Bird LED game.
// Holds COLS columns of ROWS bits (1 = pipe). Each active scroll tick shifts the
// field one column to the left and loads a new rightmost column, which is either
// a pipe whose opening is placed by the 3-bit random value, or empty.
// Optional feature macro: PIPE_SCROLLER_SPEEDUP_EN -- when defined, the spawn
// spacing shrinks by one for every 8 pipes passed, never going below 3 ticks.
module pipe_scroller #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int GAP        = 4,
    parameter int GAP_OFFSET = 2,
    parameter int SPACING    = 6,
    parameter int BIRD_COL   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     active,
    input  logic                     tick,
    input  logic [2:0]               rnd,
    input  logic [$clog2(COLS)-1:0]  rd_col,
    output logic [ROWS-1:0]          rd_data,
    output logic [ROWS-1:0]          bird_data,
    output logic                     pass,
    output logic [7:0]               score
);

    localparam int RD_W  = $clog2(COLS);
    localparam int RD_N  = 1 << RD_W;
    localparam int CNT_W = $clog2(SPACING);

    logic [ROWS-1:0]  col_r [COLS];
    logic [CNT_W-1:0] spawn_cnt_r;
    logic             pass_r;
    logic [7:0]       score_r;
    logic [CNT_W-1:0] reload_s;
    logic             step_s;
    logic [ROWS-1:0]  rd_tab_s [RD_N];

    // Pipe column: all rows solid except a GAP-tall opening starting at rnd + GAP_OFFSET.
    function automatic logic [ROWS-1:0] pipe_column(input logic [2:0] r);
        int              base;
        logic [ROWS-1:0] c;
        base = int'(r) + GAP_OFFSET;
        c    = {ROWS{1'b1}};
        for (int row = 0; row < ROWS; row++) begin
            if ((row >= base) && (row < base + GAP)) begin
                c[row] = 1'b0;
            end else begin
                c[row] = 1'b1;
            end
        end
        return c;
    endfunction

`ifdef PIPE_SCROLLER_SPEEDUP_EN
    int shrink_s;
    int eff_s;

    // Spawn-counter reload: spacing shortened by score/8, clamped at 3 ticks.
    always_comb begin
        shrink_s = int'(score_r[7:3]);
        eff_s    = SPACING - shrink_s;
        if (eff_s < 3) begin
            eff_s = 3;
        end else begin
            eff_s = eff_s;
        end
        reload_s = CNT_W'(eff_s - 1);
    end
`else
    // Spawn-counter reload: fixed spacing, score has no influence on timing.
    always_comb begin
        reload_s = CNT_W'(SPACING - 1);
    end
`endif

    // A scroll step happens only on a tick while the game is running.
    always_comb begin
        if (tick && active) begin
            step_s = 1'b1;
        end else begin
            step_s = 1'b0;
        end
    end

    // Field, spawn cadence, pass pulse and saturating score; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COLS; i++) begin
                col_r[i] <= {ROWS{1'b0}};
            end
            spawn_cnt_r <= CNT_W'(SPACING - 1);
            pass_r      <= 1'b0;
            score_r     <= 8'd0;
        end else if (step_s) begin
            for (int i = 0; i < COLS - 1; i++) begin
                col_r[i] <= col_r[i + 1];
            end
            if (spawn_cnt_r == {CNT_W{1'b0}}) begin
                col_r[COLS-1] <= pipe_column(rnd);
                spawn_cnt_r   <= reload_s;
            end else begin
                col_r[COLS-1] <= {ROWS{1'b0}};
                spawn_cnt_r   <= spawn_cnt_r - CNT_W'(1);
            end
            // The column leaving the bird position this step carries a pipe.
            if (col_r[BIRD_COL] != {ROWS{1'b0}}) begin
                pass_r <= 1'b1;
                if (score_r != 8'hFF) begin
                    score_r <= score_r + 8'd1;
                end else begin
                    score_r <= score_r;
                end
            end else begin
                pass_r <= 1'b0;
            end
        end else begin
            pass_r <= 1'b0;
        end
    end

    // Read table padded to a power of two so out-of-range selects return zero.
    genvar g;
    generate
        for (g = 0; g < RD_N; g++) begin : g_rd_tab
            if (g < COLS) begin : g_live
                assign rd_tab_s[g] = col_r[g];
            end else begin : g_pad
                assign rd_tab_s[g] = {ROWS{1'b0}};
            end
        end
    endgenerate

    assign rd_data   = rd_tab_s[rd_col];
    assign bird_data = col_r[BIRD_COL];
    assign pass      = pass_r;
    assign score     = score_r;

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller. The reference model tracks which scroll
// step spawned each pipe; a column's content is derived from how many steps ago
// its pipe was spawned, and pass/score follow from the pipe sitting at the bird.
module tb_pipe_scroller;

    localparam int ROWS       = 16;
    localparam int COLS       = 16;
    localparam int GAP        = 4;
    localparam int GAP_OFFSET = 2;
    localparam int SPACING    = 6;
    localparam int BIRD_COL   = 3;
    localparam int MAX_STEPS  = 4096;

    logic            clk = 1'b0;
    logic            reset;
    logic            active;
    logic            tick;
    logic [2:0]      rnd;
    logic [3:0]      rd_col;
    logic [ROWS-1:0] rd_data;
    logic [ROWS-1:0] bird_data;
    logic            pass;
    logic [7:0]      score;

    pipe_scroller #(
        .ROWS(ROWS), .COLS(COLS), .GAP(GAP), .GAP_OFFSET(GAP_OFFSET),
        .SPACING(SPACING), .BIRD_COL(BIRD_COL)
    ) dut (
        .clk(clk), .reset(reset), .active(active), .tick(tick), .rnd(rnd),
        .rd_col(rd_col), .rd_data(rd_data), .bird_data(bird_data),
        .pass(pass), .score(score)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int rd_fixed = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int m_steps;
    int m_next;
    int m_score;
    bit m_pass;
    bit m_sp   [MAX_STEPS];
    int m_base [MAX_STEPS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ROWS-1:0] mask_for(input int base);
        logic [31:0] m;
        m = ((32'd1 << GAP) - 32'd1) << base;
        return ~m[ROWS-1:0];
    endfunction

    function automatic int eff_spacing(input int s);
        int sp;
        sp = SPACING;
`ifdef PIPE_SCROLLER_SPEEDUP_EN
        sp = SPACING - (s / 8);
        if (sp < 3) sp = 3;
`endif
        if (s < 0) sp = SPACING;
        return sp;
    endfunction

    // Column c now holds the pipe spawned (COLS-1-c) steps ago, if any.
    function automatic logic [ROWS-1:0] exp_col(input int c);
        int k;
        k = m_steps - (COLS - 1 - c);
        if (c >= COLS) return '0;
        if (k >= 1 && k < MAX_STEPS) begin
            if (m_sp[k]) return mask_for(m_base[k]);
        end
        return '0;
    endfunction

    always @(posedge clk) begin
        int n;
        int k;
        bit p;
        if (reset) begin
            m_steps = 0;
            m_next  = SPACING;
            m_score = 0;
            m_pass  = 1'b0;
        end else if (tick && active) begin
            n = m_steps + 1;
            k = m_steps - (COLS - 1 - BIRD_COL);
            p = 1'b0;
            if (k >= 1 && k < MAX_STEPS) p = m_sp[k];
            if (n < MAX_STEPS) begin
                if (n == m_next) begin
                    m_sp[n]   = 1'b1;
                    m_base[n] = int'(rnd) + GAP_OFFSET;
                    m_next    = n + eff_spacing(m_score);
                end else begin
                    m_sp[n] = 1'b0;
                end
            end
            m_steps = n;
            m_pass  = p;
            if (p && m_score < 255) m_score = m_score + 1;
        end else begin
            m_pass = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_data", {16'd0, rd_data}, {16'd0, exp_col(int'(rd_col))});
            chk("bird_data", {16'd0, bird_data}, {16'd0, exp_col(BIRD_COL)});
            chk("pass", {31'd0, pass}, {31'd0, m_pass});
            chk("score", {24'd0, score}, {24'd0, m_score[7:0]});
        end
    end

    task automatic cyc(input logic t, input logic a, input logic rs, input logic [2:0] r);
        tick   = t;
        active = a;
        reset  = rs;
        rnd    = r;
        if (rd_fixed < 0) rd_col = 4'($urandom_range(0, 15));
        else              rd_col = 4'(rd_fixed);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] r;
        reset  = 1'b1;
        tick   = 1'b0;
        active = 1'b0;
        rnd    = 3'd0;
        rd_col = 4'd0;
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd0);
        chk_en = 1'b1;

        // Empty field after reset
        for (int c = 0; c < COLS; c++) begin
            rd_fixed = c;
            cyc(1'b0, 1'b1, 1'b0, 3'($urandom_range(0, 7)));
            chk("reset_col", {16'd0, rd_data}, 32'h0000);
        end
        chk("reset_score", {24'd0, score}, 32'd0);
        chk("reset_pass", {31'd0, pass}, 32'd0);

        // First three spawns and the first pass
        rd_fixed = 15;
        for (int t = 1; t <= 19; t++) begin
            r = 3'($urandom_range(0, 7));
            if (t == 6)  r = 3'd3;
            if (t == 12) r = 3'd0;
            if (t == 18) r = 3'd7;
            cyc(1'b1, 1'b1, 1'b0, r);
            if (t == 6)  chk("spawn_rnd3", {16'd0, rd_data}, 32'hFE1F);
            if (t == 12) chk("spawn_rnd0", {16'd0, rd_data}, 32'hFFC3);
            if (t == 18) chk("spawn_rnd7", {16'd0, rd_data}, 32'hE1FF);
            if (t == 18) chk("bird_arrive", {16'd0, bird_data}, 32'hFE1F);
            if (t % 6 != 0) chk("empty_col", {16'd0, rd_data}, 32'h0000);
            if (t <= 18) chk("no_early_pass", {31'd0, pass}, 32'd0);
        end
        chk("first_pass", {31'd0, pass}, 32'd1);
        chk("first_score", {24'd0, score}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 3'd0);
        chk("pass_single", {31'd0, pass}, 32'd0);

        // Frozen game ignores ticks and rnd
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
            cyc(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
        end
        chk("freeze_score", {24'd0, score}, 32'd1);
        chk("freeze_pass", {31'd0, pass}, 32'd0);
        for (int t = 1; t <= 5; t++) begin
            r = (t == 5) ? 3'd5 : 3'($urandom_range(0, 7));
            cyc(1'b1, 1'b1, 1'b0, r);
            if (t == 5) chk("resume_spawn", {16'd0, rd_data}, 32'hF87F);
            else        chk("resume_gap", {16'd0, rd_data}, 32'h0000);
        end

        // Random traffic
        rd_fixed = -1;
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 149) == 0), 3'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)));
        end

        // Reset coincident with a tick on a populated field
        rd_fixed = 15;
        cyc(1'b1, 1'b1, 1'b1, 3'($urandom_range(0, 7)));
        chk("midreset_score", {24'd0, score}, 32'd0);
        chk("midreset_pass", {31'd0, pass}, 32'd0);
        chk("midreset_col", {16'd0, rd_data}, 32'h0000);
        for (int t = 1; t <= 6; t++) begin
            r = (t == 6) ? 3'd1 : 3'($urandom_range(0, 7));
            cyc(1'b1, 1'b1, 1'b0, r);
            if (t == 6) chk("post_reset_spawn", {16'd0, rd_data}, 32'hFF87);
            else        chk("post_reset_gap", {16'd0, rd_data}, 32'h0000);
        end

        // Long back-to-back run to saturate the score
        rd_fixed = -1;
        for (int i = 0; i < 1620; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)));
        end
        chk("score_sat", {24'd0, score}, 32'd255);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)));
        end
        chk("score_hold", {24'd0, score}, 32'd255);

        cyc(1'b0, 1'b1, 1'b0, 3'd0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
